// File: rtl/hd_eval_pkg.sv
// Shared types for the predicate-evaluation front end: FSM states, byte width, bit index.
package hd_eval_pkg;

  localparam int BYTE_W = 8;

  typedef logic [2:0] bit_idx_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    OUTPUT  = 2'd2
  } hd_state_t;

endpackage

// File: rtl/hd_bit_deser.sv
// Serial-to-byte deserialiser: indexed bit write, zero-pads the upper bits when a frame ends mid-byte.
// close/partial/last are combinational on the accepted bit; bit_vld must already include the ready qualifier.
module hd_bit_deser
  import hd_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_vld,
  input  logic              bit_dat,
  input  logic              bit_last,
  output logic [BYTE_W-1:0] byte_dat,
  output logic              close,
  output logic              partial,
  output logic              last
);

  bit_idx_t          idx;
  logic [BYTE_W-1:0] byte_nxt;

  assign close   = bit_vld && ((idx == 3'd7) || bit_last);
  assign partial = close && (idx != 3'd7);
  assign last    = close && bit_last;

  always_comb begin
    byte_nxt = byte_dat;
    for (int i = 0; i < BYTE_W; i++) begin
      if (i == int'(idx)) begin
        byte_nxt[i] = bit_dat;
      end else if (partial && (i > int'(idx))) begin
        byte_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_dat <= '0;
      idx      <= '0;
    end else if (bit_vld) begin
      byte_dat <= byte_nxt;
      idx      <= close ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/hd_eval_frontend.sv
// Front end for the combinational predicate block: collects a byte, evaluates for one cycle, presents the result.
// Closing bit at edge N gives res_valid from edge N+2; res_ready low parks the FSM in OUTPUT with in_ready low.
module hd_eval_frontend
  import hd_eval_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             x0,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  output logic             x4,
  output logic             x5,
  output logic             x6,
  output logic             x7,
  input  logic             y0,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_byte,
  output logic             res_y,
  output logic             res_partial,
  output logic             res_last,
  output logic [CNT_W-1:0] res_count
);

  hd_state_t         state, state_nxt;
  logic              accept, handshake;
  logic              close, close_partial, close_last;
  logic [BYTE_W-1:0] byte_dat;
  logic [CNT_W-1:0]  cnt, cnt_inc;

  assign in_ready  = (state == COLLECT);
  assign res_valid = (state == OUTPUT);
  assign accept    = in_valid && in_ready;
  assign handshake = res_valid && res_ready;

  // Saturate rather than wrap so a long frame never reports a small count.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(y0);

  hd_bit_deser u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_vld  (accept),
    .bit_dat  (in_bit),
    .bit_last (in_last),
    .byte_dat (byte_dat),
    .close    (close),
    .partial  (close_partial),
    .last     (close_last)
  );

  assign {x7, x6, x5, x4, x3, x2, x1, x0} = byte_dat;
  assign res_byte = byte_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (close) state_nxt = EVAL;
      EVAL:    state_nxt = OUTPUT;
      OUTPUT:  if (res_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_y       <= 1'b0;
      res_partial <= 1'b0;
      res_last    <= 1'b0;
      res_count   <= '0;
      cnt         <= '0;
    end else begin
      if (close) begin
        res_partial <= close_partial;
        res_last    <= close_last;
      end
      if (state == EVAL) begin
        res_y     <= y0;
        res_count <= cnt_inc;
        cnt       <= cnt_inc;
      end
      if (handshake) begin
        res_partial <= 1'b0;
        if (res_last) begin
          cnt      <= '0;
          res_last <= 1'b0;
        end
      end
    end
  end

endmodule
